// File: rtl/cma_host_sequencer_pkg.sv
// rtl/cma_host_sequencer_pkg.sv - shared FSM states, image-entry layout and error causes
package cma_host_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT_DONE,
    S_DUMP,
    S_FIN,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_DONE_TMO = 2'd1
  } err_cause_t;

  // Image entry is packed {bank, romul, adr, data} from MSB to LSB.
  function automatic int img_adr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int img_romul_lsb(input int adr_w, input int data_w);
    return adr_w + data_w;
  endfunction

  function automatic int img_bank_bit(input int romul_w, input int adr_w, input int data_w);
    return romul_w + adr_w + data_w;
  endfunction

endpackage

// File: rtl/cma_rd_fifo.sv
// rtl/cma_rd_fifo.sv - synchronous read-back FIFO with occupancy count
module cma_rd_fifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         wdata,
  input  logic                 pop,
  output logic [W-1:0]         rdata,
  output logic                 empty,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign empty = (count == '0);
  // Head is masked when empty so the stream bus reads 0 after reset.
  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/cma_host_sequencer.sv
// rtl/cma_host_sequencer.sv - host driver: load image, run, wait done, dump results
module cma_host_sequencer
  import cma_host_sequencer_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADR_W    = 10,
  parameter int ROMUL_W  = 3,
  parameter int IMG_AW   = 10,
  parameter int DONE_TMO = 65535,
  parameter int OFIFO_D  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [IMG_AW-1:0]                 i_nload,
  input  logic [ADR_W-1:0]                  i_dbase,
  input  logic [ADR_W-1:0]                  i_ndump,
  output logic [IMG_AW-1:0]                 o_img_a,
  input  logic [ROMUL_W+ADR_W+DATA_W:0]     i_img_d,
  output logic                              o_cbank,
  output logic                              o_run,
  output logic                              o_exwe,
  output logic                              o_exre,
  output logic [ADR_W-1:0]                  o_exa,
  output logic [DATA_W-1:0]                 o_exwd,
  output logic [ROMUL_W-1:0]                o_exromul,
  input  logic [DATA_W-1:0]                 i_exrd,
  input  logic                              i_done,
  output logic                              o_rvalid,
  input  logic                              i_rready,
  output logic [DATA_W-1:0]                 o_rdata,
  output logic                              o_busy,
  output logic                              o_fin,
  output logic                              o_err
);
  localparam int CW        = $clog2(OFIFO_D) + 1;
  localparam int TW        = $clog2(DONE_TMO + 1);
  localparam int ADR_LSB   = img_adr_lsb(DATA_W);
  localparam int ROMUL_LSB = img_romul_lsb(ADR_W, DATA_W);
  localparam int BANK_BIT  = img_bank_bit(ROMUL_W, ADR_W, DATA_W);

  state_t            state, nstate;
  err_cause_t        err_q;
  logic [IMG_AW-1:0] nload_q, img_cnt;
  logic [ADR_W-1:0]  dbase_q, ndump_q, rd_cnt;
  logic [TW-1:0]     tmo;
  logic              wr_pend, inflight, cbank_q, fin_q, rd_go;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic              fifo_empty, pop;

  always_comb begin
    nstate = state;
    o_run  = 1'b0;
    o_busy = 1'b1;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) nstate = (i_nload == '0) ? S_RUN : S_LOAD;
      end
      S_LOAD: if (img_cnt == nload_q) nstate = S_RUN;
      S_RUN: begin
        o_run  = 1'b1;
        nstate = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        o_run = 1'b1;
        if (i_done)                         nstate = (ndump_q == '0) ? S_FIN : S_DUMP;
        else if (tmo == TW'(DONE_TMO - 1))  nstate = S_ERR;
      end
      S_DUMP: if (rd_cnt == ndump_q && !inflight && fifo_empty) nstate = S_FIN;
      S_FIN: begin
        o_busy = 1'b0;
        nstate = S_IDLE;
      end
      S_ERR: begin
        o_busy = 1'b0;
        if (i_start) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Credit counts the FIFO plus the read whose data is still on its way back.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign rd_go = (state == S_DUMP) && (rd_cnt != ndump_q) && (credit_used < (CW+1)'(OFIFO_D));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      err_q    <= ERR_NONE;
      nload_q  <= '0;
      img_cnt  <= '0;
      dbase_q  <= '0;
      ndump_q  <= '0;
      rd_cnt   <= '0;
      tmo      <= '0;
      wr_pend  <= 1'b0;
      inflight <= 1'b0;
      cbank_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state    <= nstate;
      wr_pend  <= 1'b0;
      inflight <= rd_go;
      if (wr_pend) cbank_q <= i_img_d[BANK_BIT];
      if (nstate == S_FIN) fin_q <= 1'b1;
      case (state)
        S_IDLE: if (i_start) begin
          nload_q <= i_nload;
          dbase_q <= i_dbase;
          ndump_q <= i_ndump;
          img_cnt <= '0;
          rd_cnt  <= '0;
          fin_q   <= 1'b0;
          err_q   <= ERR_NONE;
        end
        S_LOAD: if (img_cnt != nload_q) begin
          wr_pend <= 1'b1;
          img_cnt <= img_cnt + IMG_AW'(1);
        end
        S_RUN: tmo <= '0;
        S_WAIT_DONE: begin
          tmo <= tmo + TW'(1);
          if (nstate == S_ERR) err_q <= ERR_DONE_TMO;
        end
        S_DUMP: if (rd_go) rd_cnt <= rd_cnt + ADR_W'(1);
        S_ERR: if (i_start) err_q <= ERR_NONE;
        default: ;
      endcase
    end
  end

  cma_rd_fifo #(.W(DATA_W), .D(OFIFO_D)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (i_exrd),
    .pop   (pop),
    .rdata (o_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pop       = o_rvalid & i_rready;
  assign o_rvalid  = !fifo_empty;
  assign o_img_a   = img_cnt;
  assign o_exwe    = wr_pend;
  assign o_exre    = rd_go;
  assign o_exwd    = wr_pend ? i_img_d[DATA_W-1:0] : '0;
  assign o_exromul = wr_pend ? i_img_d[ROMUL_LSB +: ROMUL_W] : '0;
  assign o_cbank   = wr_pend ? i_img_d[BANK_BIT] : cbank_q;
  assign o_exa     = wr_pend ? i_img_d[ADR_LSB +: ADR_W] : (rd_go ? dbase_q + rd_cnt : '0);
  assign o_fin     = fin_q;
  assign o_err     = (err_q != ERR_NONE);

endmodule

// File: tb/tb_cma_host_sequencer.sv
// tb/tb_cma_host_sequencer.sv - scoreboard bench for cma_host_sequencer
module tb_cma_host_sequencer;
  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int RW  = 3;
  localparam int IAW = 6;
  localparam int TMO = 100;
  localparam int FD  = 4;
  localparam int IW  = 1 + RW + AW + DW;

  logic clk = 0, rst = 1, start = 0, done = 0, rready = 0;
  logic [IAW-1:0] nload = '0, img_a;
  logic [AW-1:0]  dbase = '0, ndump = '0, exa;
  logic [IW-1:0]  img_d = '0;
  logic           cbank, run, exwe, exre, rvalid, busy, fin, err;
  logic [DW-1:0]  exwd, exrd = '0, rdata;
  logic [RW-1:0]  exromul;

  cma_host_sequencer #(.DATA_W(DW), .ADR_W(AW), .ROMUL_W(RW), .IMG_AW(IAW),
                       .DONE_TMO(TMO), .OFIFO_D(FD)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_nload(nload), .i_dbase(dbase),
    .i_ndump(ndump), .o_img_a(img_a), .i_img_d(img_d), .o_cbank(cbank),
    .o_run(run), .o_exwe(exwe), .o_exre(exre), .o_exa(exa), .o_exwd(exwd),
    .o_exromul(exromul), .i_exrd(exrd), .i_done(done), .o_rvalid(rvalid),
    .i_rready(rready), .o_rdata(rdata), .o_busy(busy), .o_fin(fin), .o_err(err));

  always #5 clk = ~clk;

  logic [IW-1:0] rom [64];
  always @(posedge clk) img_d <= rom[img_a];
  always @(posedge clk) exrd <= exre ? (DW'(exa) ^ 16'h005A) : 16'hDEAD;

  int n_checks = 0, n_pass = 0;
  logic [IW-1:0] exp_wr[$];
  int exp_addr[$], exp_rd[$];
  int we_rises = 0, run_cyc = 0, rd_issued = 0, rd_acc = 0, max_out = 0;
  logic prev_we = 0;
  bit stall = 0, rd_mode = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk); #1;
    rready = stall ? 1'b0 : (rd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: pops expectations whenever the DUT presents a write, read or stream beat.
  always @(negedge clk) begin
    if (rst) begin
      rd_issued = 0; rd_acc = 0; prev_we = 0;
    end else begin
      if (start && !busy) max_out = 0;
      if (run) run_cyc++;
      if (exwe && !prev_we) we_rises++;
      prev_we = exwe;
      if (exwe || exre)
        check("mutex", !(exwe && exre) && !run, {exwe, exre, run}, 0);
      if (exwe) begin
        check("write_expected", exp_wr.size() != 0, exp_wr.size(), 1);
        if (exp_wr.size() != 0) begin
          logic [IW-1:0] e;
          e = exp_wr.pop_front();
          check("load_entry", {cbank, exromul, exa, exwd} == e, {cbank, exromul, exa, exwd}, e);
        end
      end
      if (exre) begin
        check("credit", (rd_issued - rd_acc) < FD, rd_issued - rd_acc, FD - 1);
        check("read_expected", exp_addr.size() != 0, exp_addr.size(), 1);
        if (exp_addr.size() != 0) begin
          int a;
          a = exp_addr.pop_front();
          check("read_addr", int'(exa) == a, exa, a);
        end
        rd_issued++;
        if (rd_issued - rd_acc > max_out) max_out = rd_issued - rd_acc;
      end
      if (rvalid && rready) begin
        check("stream_expected", exp_rd.size() != 0, exp_rd.size(), 1);
        if (exp_rd.size() != 0) begin
          int d;
          d = exp_rd.pop_front();
          check("stream_data", int'(rdata) == d, rdata, d);
        end
        rd_acc++;
      end
    end
  end

  task automatic do_start(input int nl, input int db, input int nd);
    @(posedge clk); #1;
    nload = IAW'(nl); dbase = AW'(db); ndump = AW'(nd); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  // dly < 1 means done is never raised; bp stalls the stream for 20 cycles once dump starts.
  task automatic run_job(input int nl, input int db, input int nd, input int dly,
                         input bit rmode, input bit bp);
    int we0, run0, cyc, stall_cnt;
    bit saw, exp_err, prev_run;
    exp_err = (dly < 1);
    for (int i = 0; i < nl; i++) exp_wr.push_back(rom[i]);
    if (!exp_err)
      for (int k = 0; k < nd; k++) begin
        exp_addr.push_back((db + k) % (1 << AW));
        exp_rd.push_back(((db + k) % (1 << AW)) ^ 'h5A);
      end
    we0 = we_rises; run0 = run_cyc; rd_mode = rmode;
    do_start(nl, db, nd);
    @(negedge clk);
    check("busy_after_start", busy && !fin && !err, {busy, fin, err}, 3'b100);
    cyc = 0;
    while (!run && cyc < 200) begin @(negedge clk); cyc++; end
    check("run_rises", run, run, 1);
    if (!exp_err) begin
      repeat (dly) @(posedge clk);
      #1 done = 1;
      @(posedge clk); #1 done = 0;
    end
    cyc = 0; stall_cnt = 0; saw = 0; prev_run = 1;
    do begin
      @(negedge clk); cyc++;
      if (prev_run && !run) check("err_at_run_drop", err == exp_err, err, exp_err);
      prev_run = run;
      if (bp && exre) saw = 1;
      if (bp && saw && stall_cnt < 20) begin stall = 1; stall_cnt++; end
      else stall = 0;
    end while (!(!busy && (fin || err)) && cyc < 3000);
    stall = 0;
    check("job_ends", !busy && (fin || err), {busy, fin, err}, 0);
    check("fin_flag", fin == !exp_err, fin, !exp_err);
    check("err_flag", err == exp_err, err, exp_err);
    check("run_cycles", run_cyc - run0 == (exp_err ? TMO + 1 : dly + 1), run_cyc - run0,
          exp_err ? TMO + 1 : dly + 1);
    check("load_burst", we_rises - we0 == (nl > 0 ? 1 : 0), we_rises - we0, nl > 0);
    check("writes_drained", exp_wr.size() == 0, exp_wr.size(), 0);
    check("reads_drained", exp_rd.size() == 0 && exp_addr.size() == 0, exp_rd.size(), 0);
    if (bp) check("max_outstanding", max_out == FD, max_out, FD);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = IW'($urandom);
    rom[0] = {1'b1, 3'd5, 10'h010, 16'h000A};
    rom[1] = {1'b0, 3'd0, 10'h020, 16'h000B};
    rom[2] = {1'b0, 3'd0, 10'h021, 16'h000C};
    @(negedge clk);
    check("reset_outputs", {run, exwe, exre, rvalid, busy, fin, err, cbank, exa, exwd, exromul, img_a, rdata} == 0,
          {run, exwe, exre, rvalid, busy, fin, err}, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    check("idle_after_reset", {busy, fin, err, run} == 0, {busy, fin, err, run}, 0);

    run_job(3, 'h100, 6, 50, 0, 0);
    run_job(2, 'h37, 12, 10, 0, 1);
    run_job(1, 0, 4, -1, 0, 0);
    do_start(0, 0, 0);
    @(negedge clk);
    check("err_cleared", {err, busy, run} == 0, {err, busy, run}, 0);
    run_job(0, 5, 3, 7, 1, 0);
    run_job(0, 0, 0, 20, 0, 0);
    run_job(0, (1 << AW) - 2, 4, 3, 0, 0);

    // Reset while reads are stalled in the dump phase.
    for (int i = 0; i < 2; i++) exp_wr.push_back(rom[i]);
    for (int k = 0; k < 10; k++) begin
      exp_addr.push_back(k + 'h40); exp_rd.push_back((k + 'h40) ^ 'h5A);
    end
    stall = 1;
    do_start(2, 'h40, 10);
    begin
      int cyc;
      cyc = 0;
      while (!run && cyc < 100) begin @(negedge clk); cyc++; end
      @(posedge clk); #1 done = 1; @(posedge clk); #1 done = 0;
      cyc = 0;
      while (rd_issued < 3 && cyc < 100) begin @(negedge clk); cyc++; end
      check("dump_reached", rd_issued >= 3, rd_issued, 3);
    end
    @(posedge clk); #3 rst = 1;
    #1;
    check("async_reset", {run, exwe, exre, rvalid, busy, fin, err, cbank, exa, exwd, exromul, img_a, rdata} == 0,
          {run, exwe, exre, rvalid, busy}, 0);
    exp_wr.delete(); exp_addr.delete(); exp_rd.delete();
    @(negedge clk); @(negedge clk);
    rst = 0; stall = 0;
    @(negedge clk);
    check("fifo_flushed", !rvalid && !busy, {rvalid, busy}, 0);
    run_job(2, 'h3F0, 5, 4, 1, 0);

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 8; i++) rom[i] = IW'($urandom);
      run_job($urandom_range(0, 8), $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 10),
              $urandom_range(1, 40), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end
endmodule
